// File: rtl/dual_lane_pkg.sv
// Shared types and default widths for the dual-lane popcount accumulator.
// State encoding and default DW/FRAME_LEN-derived counter widths live here.
package dual_lane_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEF_DW        = 8;
  localparam int DEF_FRAME_LEN = 4;
  localparam int DEF_CW        = $clog2(DEF_DW * DEF_FRAME_LEN + 1);
  localparam int DEF_BW        = $clog2(DEF_FRAME_LEN + 1);

endpackage

// File: rtl/lane_popcount.sv
// Combinational population count of one DW-bit lane, zero-extended to CW bits.
module lane_popcount
  import dual_lane_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int CW = DEF_CW
) (
  input  logic [DW-1:0] data,
  output logic [CW-1:0] count
);

  integer i;

  // NOTE: combinational logic uses blocking '=' and assigns every output before any
  // conditional/loop update, so no latch can be inferred.
  always_comb begin
    count = '0;
    for (i = 0; i < DW; i = i + 1) begin
      count = count + CW'(data[i]);
    end
  end

endmodule

// File: rtl/dual_lane_bitcount.sv
// Per-frame, per-lane popcount accumulator with valid/ready on both sides.
// Optional build macro DUAL_LANE_PARITY_EN adds per-lane frame parity outputs par0/par1.
module dual_lane_bitcount
  import dual_lane_pkg::*;
#(
  parameter int  DW        = DEF_DW,
  parameter int  FRAME_LEN = DEF_FRAME_LEN,
  localparam int CW        = $clog2(DW * FRAME_LEN + 1),
  localparam int BW        = $clog2(FRAME_LEN + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_last,
  input  logic [DW-1:0] lane0,
  input  logic [DW-1:0] lane1,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] cnt0,
  output logic [CW-1:0] cnt1,
  output logic [BW-1:0] beats
`ifdef DUAL_LANE_PARITY_EN
  ,
  output logic          par0,
  output logic          par1
`endif
);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt0_q, cnt0_d;
  logic [CW-1:0] cnt1_q, cnt1_d;
  logic [BW-1:0] beats_q, beats_d;
  logic [BW-1:0] beats_inc;
  logic [CW-1:0] pc0, pc1;
  logic          acc;

  lane_popcount #(.DW(DW), .CW(CW)) u_pc0 (.data(lane0), .count(pc0));
  lane_popcount #(.DW(DW), .CW(CW)) u_pc1 (.data(lane1), .count(pc1));

  // Both handshake flags are pure decodes of the registered state.
  assign in_ready  = (state_q != DONE);
  assign out_valid = (state_q == DONE);
  assign acc       = in_valid & in_ready;
  assign beats_inc = beats_q + BW'(1);

`ifdef DUAL_LANE_PARITY_EN
  // Lane parity for a beat is the LSB of its popcount; frame parity XOR-accumulates it.
  logic par0_q, par0_d;
  logic par1_q, par1_d;
  assign par0 = par0_q;
  assign par1 = par1_q;
`endif

  always_comb begin
    state_d = state_q;
    cnt0_d  = cnt0_q;
    cnt1_d  = cnt1_q;
    beats_d = beats_q;
`ifdef DUAL_LANE_PARITY_EN
    par0_d  = par0_q;
    par1_d  = par1_q;
`endif
    case (state_q)
      IDLE: begin
        if (acc) begin
          cnt0_d  = pc0;
          cnt1_d  = pc1;
          beats_d = BW'(1);
`ifdef DUAL_LANE_PARITY_EN
          par0_d  = pc0[0];
          par1_d  = pc1[0];
`endif
          state_d = (in_last || FRAME_LEN == 1) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (acc) begin
          cnt0_d  = cnt0_q + pc0;
          cnt1_d  = cnt1_q + pc1;
          beats_d = beats_inc;
`ifdef DUAL_LANE_PARITY_EN
          par0_d  = par0_q ^ pc0[0];
          par1_d  = par1_q ^ pc1[0];
`endif
          if (in_last || beats_inc == BW'(FRAME_LEN)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          cnt0_d  = '0;
          cnt1_d  = '0;
          beats_d = '0;
`ifdef DUAL_LANE_PARITY_EN
          par0_d  = 1'b0;
          par1_d  = 1'b0;
`endif
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values;
  // all accumulators are reset because a partial frame must vanish on rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
      beats_q <= '0;
`ifdef DUAL_LANE_PARITY_EN
      par0_q  <= 1'b0;
      par1_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
      beats_q <= beats_d;
`ifdef DUAL_LANE_PARITY_EN
      par0_q  <= par0_d;
      par1_q  <= par1_d;
`endif
    end
  end

  assign cnt0  = cnt0_q;
  assign cnt1  = cnt1_q;
  assign beats = beats_q;

endmodule
